offchip_line_responder: RTL and testbench
=========================================

// Module: offchip_line_responder
// PURPOSE
//  Memory-side responder of the off-chip instruction line channel (offchip_mem_read_en/addr -> data/ready/busy).
//  Accepts one cache-line read, fetches it as 32-bit words from a word-wide backing memory port,
//  assembles LINE_BYTES bytes and returns the whole line with a one-cycle ready pulse.
//  Sits between the core's line-fill requester and the board SRAM/flash controller.
// PARAMETERS
//  LINE_BYTES  `CACHE_LINE_SIZE (32)  line size in bytes; power of two, >=4
//  ADDR_W      32                     address width of both ports
// PORTS
//  clk                input   1              system clock
//  rst                input   1              asynchronous active-low reset
//  offchip_mem_read_en input  1              line read request (level; requester holds until ready)
//  offchip_mem_addr   input   ADDR_W         byte address of requested line (any alignment)
//  offchip_mem_data   output  LINE_BYTES*8   assembled line, valid while ready=1
//  offchip_mem_ready  output  1              one-cycle pulse: line data valid
//  offchip_mem_read_busy output 1            responder owns a request (not IDLE)
//  line_inval         input   1              drop buffered line (used only with LAST_LINE_EN)
//  mem_req            output  1              backing word read request
//  mem_addr           output  ADDR_W         backing word address (4-byte aligned)
//  mem_gnt            input   1              backing accepted mem_req this cycle
//  mem_rdata          input   32             backing read word
//  mem_rvalid         input   1              mem_rdata valid (exactly one per granted req)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; data=0, ready=0, busy=0, mem_req=0, mem_addr=0, word idx=0, line buffer invalid.
//   Reset mid-fetch aborts; backing controller shares rst so no stale rvalid survives.
//  FSM IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
//   IDLE: read_en=1 -> latch base = addr with low log2(LINE_BYTES) bits cleared, idx=0, go REQ.
//   REQ : mem_req=1, mem_addr=base+4*idx; mem_gnt=1 -> WAIT (mem_req drops next cycle).
//   WAIT: mem_rvalid=1 -> data[32*idx+:32]=mem_rdata (little-endian word order); idx==WORDS-1 -> DONE else idx++ -> REQ.
//   DONE: ready=1 for exactly this cycle -> IDLE. read_en ignored in DONE (one-cycle gap between lines).
//  WORDS = LINE_BYTES/4; idx width log2(WORDS), wraps only via reset to 0 on new accept.
//  One outstanding backing read; rvalid in REQ is a protocol error and is ignored.
//  Latency (gnt same cycle, rvalid next): accept cycle 0, ready at cycle 1+2*WORDS (17 for 32 B).
//  busy=1 in REQ, WAIT, DONE; 0 in IDLE. addr/read_en changes after acceptance are ignored.
//  data holds last assembled line after ready until overwritten by the next fill.
// CONFIGURATION
//  OFFCHIP_RESP_LAST_LINE_EN defined: keep tag (base) + valid of last completed line.
//   IDLE with read_en=1 and aligned addr == tag and valid -> go straight to DONE, no backing traffic; ready next cycle.
//   valid set on DONE of a backing fill; cleared by reset or line_inval (line_inval in the compare cycle forces miss).
//  Not defined: every request fetches from backing memory; line_inval ignored, tag logic absent.
// STRUCTURE
//  config.v: CACHE_LINE_SIZE, FSM state encodings (RESP_IDLE/REQ/WAIT/DONE), word-size constant.
//  Sub-module line_word_packer: idx counter + word-lane write into LINE_BYTES*8 register, last-word flag.
//  Top holds FSM, address latch, backing handshake and optional tag buffer.
// TESTING
//  Reset: rst low mid-WAIT -> ready=0, busy=0, mem_req=0 same cycle; after release, next request starts at word 0.
//  Fill: read_en, addr=0x8000_0014, backing gnt immediate, rdata=addr -> mem_addr 0x8000_0000..0x1C, ready at cycle 17, data word i = 0x8000_0000+4i.
//  Backpressure: gnt delayed 3 cycles per word, rvalid delayed 2 -> mem_addr stable while mem_req, ready exactly once, busy high throughout.
//  Back-to-back: read_en held high across ready -> one idle cycle, second line accepted, no duplicate ready.
//  LAST_LINE_EN: repeat 0x8000_0004 after fill of 0x8000_0000 -> ready 1 cycle later, zero mem_req; after line_inval -> full refetch.

Source files
------------

// File: rtl/offchip_line_responder_pkg.sv
// Shared constants and FSM encoding for the off-chip instruction line responder.
package offchip_line_responder_pkg;

  localparam int CACHE_LINE_SIZE = 32;
  localparam int WORD_BYTES      = 4;
  localparam int WORD_BITS       = WORD_BYTES * 8;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_REQ  = 2'd1,
    RESP_WAIT = 2'd2,
    RESP_DONE = 2'd3
  } resp_state_e;

  // Word-index width; a one-word line still needs a 1-bit index.
  function automatic int idxWidth(input int lineBytes);
    return (lineBytes / WORD_BYTES > 1) ? $clog2(lineBytes / WORD_BYTES) : 1;
  endfunction

endpackage

// File: rtl/offchip_line_responder_line_word_packer.sv
// Word index counter plus lane write of 32-bit backing words into the line register.
module line_word_packer
  import offchip_line_responder_pkg::*;
#(
  parameter int LINE_BYTES = CACHE_LINE_SIZE,
  localparam int WORDS     = LINE_BYTES / WORD_BYTES,
  localparam int IDX_W     = idxWidth(LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    wr_i,
  input  logic [WORD_BITS-1:0]    wdata_i,
  output logic [LINE_BYTES*8-1:0] line_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    last_o
);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [LINE_BYTES*8-1:0] line_q, line_d;

  assign last_o = (idx_q == IDX_W'(WORDS - 1));
  assign idx_o  = idx_q;
  assign line_o = line_q;

  // The index stays on the last word after the final write; only a new accept rewinds it.
  always_comb begin
    idx_d  = idx_q;
    line_d = line_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (wr_i) begin
      line_d[idx_q*WORD_BITS +: WORD_BITS] = wdata_i;
      if (!last_o) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      line_q <= '0;
    end else begin
      idx_q  <= idx_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/offchip_line_responder.sv
// Memory-side responder: fetches one cache line word by word and returns it with a ready pulse.
// Define OFFCHIP_RESP_LAST_LINE_EN to answer repeat requests for the last filled line without backing traffic.
module offchip_line_responder
  import offchip_line_responder_pkg::*;
#(
  parameter int LINE_BYTES = CACHE_LINE_SIZE,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    offchip_mem_read_en,
  input  logic [ADDR_W-1:0]       offchip_mem_addr,
  output logic [LINE_BYTES*8-1:0] offchip_mem_data,
  output logic                    offchip_mem_ready,
  output logic                    offchip_mem_read_busy,
  input  logic                    line_inval,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_gnt,
  input  logic [WORD_BITS-1:0]    mem_rdata,
  input  logic                    mem_rvalid
);

  localparam int IDX_W = idxWidth(LINE_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

  resp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] reqBase;
  logic [IDX_W-1:0]  idx;
  logic              accept, wordWr, lastWord, fillDone, hit;

  assign reqBase  = offchip_mem_addr & ~OFF_MASK;
  assign wordWr   = (state_q == RESP_WAIT) && mem_rvalid;
  assign fillDone = wordWr && lastWord;

`ifdef OFFCHIP_RESP_LAST_LINE_EN
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              tagValid_q, tagValid_d;

  // An invalidate in the compare cycle must turn a would-be hit into a refetch.
  assign hit = tagValid_q && !line_inval && (reqBase == tag_q);

  always_comb begin
    tag_d      = tag_q;
    tagValid_d = tagValid_q;
    if (line_inval) begin
      tagValid_d = 1'b0;
    end else if (fillDone) begin
      tagValid_d = 1'b1;
      tag_d      = base_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q      <= '0;
      tagValid_q <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      tagValid_q <= tagValid_d;
    end
  end
`else
  logic unused_lineInval;
  assign unused_lineInval = line_inval;
  assign hit              = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    accept  = 1'b0;
    case (state_q)
      RESP_IDLE: begin
        if (offchip_mem_read_en) begin
          if (hit) begin
            state_d = RESP_DONE;
          end else begin
            state_d = RESP_REQ;
            base_d  = reqBase;
            accept  = 1'b1;
          end
        end
      end
      RESP_REQ:  if (mem_gnt) state_d = RESP_WAIT;
      RESP_WAIT: if (mem_rvalid) state_d = lastWord ? RESP_DONE : RESP_REQ;
      RESP_DONE: state_d = RESP_IDLE;
      default:   state_d = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESP_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Outputs decode the state register directly so an async reset clears them immediately.
  assign mem_req               = (state_q == RESP_REQ);
  assign mem_addr              = mem_req ? (base_q + (ADDR_W'(idx) << 2)) : '0;
  assign offchip_mem_ready     = (state_q == RESP_DONE);
  assign offchip_mem_read_busy = (state_q != RESP_IDLE);

  line_word_packer #(
    .LINE_BYTES(LINE_BYTES)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(accept),
    .wr_i   (wordWr),
    .wdata_i(mem_rdata),
    .line_o (offchip_mem_data),
    .idx_o  (idx),
    .last_o (lastWord)
  );

endmodule

// File: tb/tb_offchip_line_responder.sv
// Scoreboard bench for offchip_line_responder: expected backing addresses and lines are queued at issue, a monitor checks them.
`timescale 1ns/1ps
module tb_offchip_line_responder;
  import offchip_line_responder_pkg::*;

  localparam int LB    = 32;
  localparam int WORDS = LB / 4;
  localparam int AW    = 32;

  logic            clk;
  logic            rst;
  logic            offchip_mem_read_en;
  logic [AW-1:0]   offchip_mem_addr;
  logic [LB*8-1:0] offchip_mem_data;
  logic            offchip_mem_ready;
  logic            offchip_mem_read_busy;
  logic            line_inval;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_gnt;
  logic [31:0]     mem_rdata;
  logic            mem_rvalid;

  int tests;
  int fails;
  int cyc;
  int grants;
  int gntDelay;
  int rvDelay;
  logic [31:0] rdataMask;

  logic [LB*8-1:0] lineQ[$];
  logic [AW-1:0]   addrQ[$];

  offchip_line_responder #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .offchip_mem_read_en  (offchip_mem_read_en),
    .offchip_mem_addr     (offchip_mem_addr),
    .offchip_mem_data     (offchip_mem_data),
    .offchip_mem_ready    (offchip_mem_ready),
    .offchip_mem_read_busy(offchip_mem_read_busy),
    .line_inval           (line_inval),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_gnt              (mem_gnt),
    .mem_rdata            (mem_rdata),
    .mem_rvalid           (mem_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [LB*8-1:0] act, input logic [LB*8-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failEvent(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: event occurred, none expected", name);
  endtask

  // Backing memory: grant after gntDelay REQ cycles, return rdata = addr ^ rdataMask rvDelay cycles later.
  initial begin : backing
    logic          pend;
    logic [AW-1:0] pAddr;
    int            gc;
    int            rc;
    pend = 1'b0; pAddr = '0; gc = 0; rc = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (rc == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pAddr ^ rdataMask;
            pend       = 1'b0;
          end else rc--;
        end
        if (!mem_req) gc = gntDelay;
        else if (!pend) begin
          if (gc == 0) begin
            mem_gnt = 1'b1;
            pend    = 1'b1;
            pAddr   = mem_addr;
            rc      = rvDelay;
            gc      = gntDelay;
          end else gc--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every granted backing request and on every ready pulse.
  initial begin : monitor
    logic          prevWaiting;
    logic [AW-1:0] prevAddr;
    prevWaiting = 1'b0; prevAddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        if (mem_req && prevWaiting) checkOutput("mem_addr_stable", mem_addr, prevAddr);
        prevWaiting = mem_req && !mem_gnt;
        prevAddr    = mem_addr;
        if (mem_req && mem_gnt) begin
          grants++;
          if (addrQ.size() == 0) failEvent("unexpected_mem_req");
          else checkOutput("mem_addr", mem_addr, addrQ.pop_front());
        end
        if (offchip_mem_ready) begin
          if (lineQ.size() == 0) failEvent("unexpected_ready");
          else checkOutput("line_data", offchip_mem_data, lineQ.pop_front());
        end
      end else prevWaiting = 1'b0;
    end
  end

  function automatic logic [LB*8-1:0] expLine(input logic [AW-1:0] addr);
    logic [AW-1:0]   base;
    logic [LB*8-1:0] line;
    base = addr & ~AW'(LB - 1);
    for (int i = 0; i < WORDS; i++) line[32*i +: 32] = (base + AW'(4 * i)) ^ rdataMask;
    return line;
  endfunction

  task automatic pushExpected(input logic [AW-1:0] addr, input bit fetches);
    logic [AW-1:0] base;
    base = addr & ~AW'(LB - 1);
    if (fetches) for (int i = 0; i < WORDS; i++) addrQ.push_back(base + AW'(4 * i));
    lineQ.push_back(expLine(addr));
  endtask

  task automatic waitReady(output bit seen, output bit busyOk);
    seen = 1'b0;
    busyOk = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (!offchip_mem_read_busy) busyOk = 1'b0;
      if (offchip_mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input int expLat, input int expReqs);
    int start;
    int startGr;
    bit seen;
    bit busyOk;
    pushExpected(addr, expReqs > 0);
    @(negedge clk);
    offchip_mem_read_en = 1'b1;
    offchip_mem_addr    = addr;
    start   = cyc;
    startGr = grants;
    @(posedge clk);
    #1;
    offchip_mem_addr = 32'hDEAD_BEEC;
    waitReady(seen, busyOk);
    offchip_mem_read_en = 1'b0;
    if (!seen) failEvent("ready_timeout");
    else checkOutput("ready_latency", cyc - start, expLat);
    checkOutput("busy_during_fill", busyOk, 1'b1);
    checkOutput("grant_count", grants - startGr, expReqs);
    @(negedge clk);
    #1;
    checkOutput("ready_pulse_width", offchip_mem_ready, 1'b0);
    checkOutput("busy_after_done", offchip_mem_read_busy, 1'b0);
  endtask

  task automatic backToBack(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int r1;
    bit seen;
    bit busyOk;
    pushExpected(a0, 1'b1);
    pushExpected(a1, 1'b1);
    @(negedge clk);
    offchip_mem_read_en = 1'b1;
    offchip_mem_addr    = a0;
    waitReady(seen, busyOk);
    r1 = cyc;
    offchip_mem_addr = a1;
    if (!seen) failEvent("b2b_first_timeout");
    @(negedge clk);
    #1;
    checkOutput("b2b_idle_gap_busy", offchip_mem_read_busy, 1'b0);
    waitReady(seen, busyOk);
    offchip_mem_read_en = 1'b0;
    if (!seen) failEvent("b2b_second_timeout");
    else checkOutput("b2b_spacing", cyc - r1, 18);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    tests = 0; fails = 0; grants = 0;
    gntDelay = 0; rvDelay = 0; rdataMask = '0;
    rst = 1'b0; offchip_mem_read_en = 1'b0; offchip_mem_addr = '0; line_inval = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_ready", offchip_mem_ready, 1'b0);
    checkOutput("reset_busy", offchip_mem_read_busy, 1'b0);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, '0);
    checkOutput("reset_data", offchip_mem_data, '0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(32'h8000_0014, 17, WORDS);
    rdataMask = 32'hA5A5_0000;
    applyStimulus(32'h0000_1000, 17, WORDS);

    gntDelay = 3; rvDelay = 2;
    applyStimulus(32'h1234_567F, 1 + WORDS * (gntDelay + 1 + rvDelay + 1), WORDS);
    gntDelay = 0; rvDelay = 0;

    backToBack(32'h0000_2000, 32'h0000_203C);

    // Abort mid-WAIT with a long backing delay, then check that a new request restarts at word 0.
    rvDelay = 20;
    addrQ.push_back(32'h4000_0040);
    @(negedge clk);
    offchip_mem_read_en = 1'b1;
    offchip_mem_addr    = 32'h4000_0040;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("pre_reset_busy", offchip_mem_read_busy, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", offchip_mem_ready, 1'b0);
    checkOutput("abort_busy", offchip_mem_read_busy, 1'b0);
    checkOutput("abort_mem_req", mem_req, 1'b0);
    checkOutput("abort_data", offchip_mem_data, '0);
    offchip_mem_read_en = 1'b0;
    addrQ.delete();
    lineQ.delete();
    @(negedge clk);
    rst = 1'b1;
    rvDelay = 0;
    applyStimulus(32'h4000_0048, 17, WORDS);

    rdataMask = '0;
    applyStimulus(32'h8000_0000, 17, WORDS);
`ifdef OFFCHIP_RESP_LAST_LINE_EN
    applyStimulus(32'h8000_0004, 1, 0);
`else
    applyStimulus(32'h8000_0004, 17, WORDS);
`endif
    @(negedge clk);
    line_inval = 1'b1;
    @(negedge clk);
    line_inval = 1'b0;
    applyStimulus(32'h8000_0004, 17, WORDS);

    repeat (5) @(negedge clk);
    checkOutput("lines_drained", lineQ.size(), 0);
    checkOutput("addrs_drained", addrQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
